load_store_queue: RTL
=====================

# load_store_queue

Parametrised in-order load/store queue between the issue stage and the memory controller. It holds up to 2**LSQ_WIDTH memory ops. It captures operands from the RS and LSQ result broadcasts and sends one access at a time to the memory controller. Stores, and optionally IO loads, are held until their op is the ROB head. Load results are sign- or zero-extended and broadcast to the ROB, RS and the queue itself.

## Interface
- ROB_WIDTH, 4, ROB index width; index 0 means "no dependency" and is never allocated
- LSQ_WIDTH, 4, log2 of queue depth; depth = 2**LSQ_WIDTH entries, all usable
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; when 0, all state holds
- clr_in  in  1  mispredict flush
- lsq_full  out  1  count == depth
- issue_lsq_ready  in  1  enqueue strobe; never asserted while lsq_full
- issue_rob_index  in  ROB_WIDTH  destination ROB entry
- issue_val1, issue_val2  in  32  base / store data
- issue_depend1, issue_depend2  in  ROB_WIDTH  producer tags; 0 = value valid
- issue_op_id  in  6  OP_LB..OP_SW from the shared consts
- issue_offset  in  32  immediate
- rs_ready, rs_rob_index, rs_val  in  1/ROB_WIDTH/32  RS broadcast
- rob_head_index  in  ROB_WIDTH  current ROB head
- lsq_ready, lsq_rob_index, lsq_val  out  1/ROB_WIDTH/32  result broadcast, one-cycle pulse
- lsq_to_mc_ready, lsq_to_mc_op, lsq_to_mc_len, lsq_to_mc_addr, lsq_to_mc_data  out  1/1/3/32/32  request; op 1 = store; len 1, 2 or 4
- mc_to_lsq_ready, mc_to_lsq_data  in  1/32  completion pulse, load data

## Operation
- Circular FIFO with head and tail pointers plus a count. Wrap is natural modulo depth.
- Wake-up: every cycle, each valid entry compares depend1 and depend2 against rs_rob_index (when rs_ready) and against lsq_rob_index (when lsq_ready). On a match it copies the value and clears the tag.
- An enqueuing op receives the same comparison, so a broadcast in the enqueue cycle is not lost.
- FSM has two states, IDLE and WAIT.
- In IDLE, the head entry dispatches when both tags are 0 and either:
  - it is a load, or
  - it is a store and rob_index == rob_head_index.
- On dispatch: addr = val1 + offset (32-bit wrap), data = val2, head advances, state goes to WAIT.
- In WAIT, on mc_to_lsq_ready:
  - Drop lsq_to_mc_ready and pulse lsq_ready with lsq_rob_index.
  - lsq_val: LB sign-extends bits 7:0; LBU zero-extends; LH/LHU likewise on bits 15:0; LW is the full word; stores give 0.
  - Return to IDLE.
- Enqueue and dispatch in the same cycle are allowed; count is unchanged.
- Flush (clr_in):
  - All queued entries are discarded: head = tail, count = 0.
  - An access in WAIT still completes at the memory controller, but its lsq_ready is suppressed. A kill flag is set and cleared on completion.
  - A store in WAIT is already committed by definition and is allowed to finish.

## Timing
- Reset values: lsq_ready 0, lsq_to_mc_ready 0, lsq_full 0, lsq_rob_index 0, lsq_val 0, lsq_to_mc_op/len/addr/data 0. FSM in IDLE, count 0.
- Enqueue at edge N makes the entry dispatchable at edge N+1, giving lsq_to_mc_ready high after N+1.
- lsq_ready rises at the edge that samples mc_to_lsq_ready and lasts exactly one cycle.
- The next dispatch happens no earlier than the edge after that.
- lsq_full reflects the registered count. Full followed by a dispatch frees a slot on the next cycle.
- Reset during WAIT aborts the request immediately.

## Configuration
- LSQ_IO_ORDER_EN defined: a load whose computed address is >= IO_BASE dispatches only when rob_index == rob_head_index, so IO reads are never speculative.
- LSQ_IO_ORDER_EN undefined: all loads dispatch as soon as their operands are ready.

## Structure
- Shared package/consts: OP_* codes and the OPCODE_S constant, plus a length-decode function (op_id to len) and a load-extend function (op_id, raw data to lsq_val).
- One sub-module, lsq_wakeup_cmp: a per-entry tag compare and value select, instantiated twice per entry.

## Test plan
- Reset then LW at ROB index 3, base 0x100, offset 4, no dependencies: request addr 0x104, len 4, op 0. Completion data 0xDEADBEEF gives a one-cycle lsq_ready with index 3 and val 0xDEADBEEF.
- LB vs LBU with data 0x80: LB gives 0xFFFFFF80, LBU gives 0x00000080. LH on 0x8001 gives 0xFFFF8001.
- SW at ROB 5 with rob_head_index 4: no request issues. Raise the head to 5: request op 1, len 4, addr/data correct the next cycle.
- Load with depend1=7, then an RS broadcast of tag 7, val 0x200, in the same cycle as enqueue: entry captures the value and dispatches with addr 0x200 + offset.
- Fill 16 entries: lsq_full is 1 and no overwrite occurs. Pointer wrap is checked by dispatching and enqueueing 40 ops in total.
- clr_in during WAIT of a load: no lsq_ready on completion, queue empty, next issued op dispatches normally. With LSQ_IO_ORDER_EN, a load to 0x30000 waits for the ROB head.

Source files
------------

// File: rtl/load_store_queue_pkg.sv
// Shared constants and helpers for the load/store queue: memory op codes,
// their major opcode class, access-length decode and load-result extension.
package load_store_queue_pkg;

  // Major opcode classes of the memory instructions.
  localparam logic [6:0] OPCODE_L = 7'b0000011;
  localparam logic [6:0] OPCODE_S = 7'b0100011;

  // Decoded memory op ids as delivered by the issue stage.
  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsq_state_e;

  // Major opcode class of a memory op id.
  function automatic logic [6:0] op_opcode(input logic [5:0] op_id);
    case (op_id)
      OP_SB, OP_SH, OP_SW: return OPCODE_S;
      default:             return OPCODE_L;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op_id);
    return op_opcode(op_id) == OPCODE_S;
  endfunction

  // Access length in bytes.
  function automatic logic [2:0] op_len(input logic [5:0] op_id);
    case (op_id)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  // Sign/zero extension of raw memory data; stores report 0.
  function automatic logic [31:0] load_extend(input logic [5:0] op_id,
                                              input logic [31:0] raw);
    case (op_id)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  return {24'h0, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  return {16'h0, raw[15:0]};
      OP_LW:   return raw;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_queue_wakeup_cmp.sv
// lsq_wakeup_cmp: one operand's tag compare against the RS and LSQ result
// broadcasts. A matching non-zero tag takes the broadcast value and clears.
module lsq_wakeup_cmp
  import load_store_queue_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input  logic [ROB_WIDTH-1:0] dep_i,
  input  logic [31:0]          val_i,
  input  logic                 rs_ready_i,
  input  logic [ROB_WIDTH-1:0] rs_index_i,
  input  logic [31:0]          rs_val_i,
  input  logic                 lsq_ready_i,
  input  logic [ROB_WIDTH-1:0] lsq_index_i,
  input  logic [31:0]          lsq_val_i,
  output logic [ROB_WIDTH-1:0] dep_o,
  output logic [31:0]          val_o
);

  // Select the captured value when a broadcast resolves the pending tag.
  always_comb begin
    // NOTE: outputs get a default before any branch so no latch is inferred.
    dep_o = dep_i;
    val_o = val_i;
    if (dep_i != '0) begin
      if (rs_ready_i && rs_index_i == dep_i) begin
        dep_o = '0;
        val_o = rs_val_i;
      end else if (lsq_ready_i && lsq_index_i == dep_i) begin
        dep_o = '0;
        val_o = lsq_val_i;
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// load_store_queue: in-order queue of memory ops between issue and the memory
// controller. One access in flight at a time; stores wait for the ROB head.
// Build option LSQ_IO_ORDER_EN: loads at or above IO_BASE also wait for the
// ROB head so IO reads are never speculative.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int          ROB_WIDTH = 4,
  parameter int          LSQ_WIDTH = 4,
  parameter logic [31:0] IO_BASE   = 32'h30000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  output logic                 lsq_full,
  input  logic                 issue_lsq_ready,
  input  logic [ROB_WIDTH-1:0] issue_rob_index,
  input  logic [31:0]          issue_val1,
  input  logic [31:0]          issue_val2,
  input  logic [ROB_WIDTH-1:0] issue_depend1,
  input  logic [ROB_WIDTH-1:0] issue_depend2,
  input  logic [5:0]           issue_op_id,
  input  logic [31:0]          issue_offset,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_index,
  input  logic [31:0]          rs_val,
  input  logic [ROB_WIDTH-1:0] rob_head_index,
  output logic                 lsq_ready,
  output logic [ROB_WIDTH-1:0] lsq_rob_index,
  output logic [31:0]          lsq_val,
  output logic                 lsq_to_mc_ready,
  output logic                 lsq_to_mc_op,
  output logic [2:0]           lsq_to_mc_len,
  output logic [31:0]          lsq_to_mc_addr,
  output logic [31:0]          lsq_to_mc_data,
  input  logic                 mc_to_lsq_ready,
  input  logic [31:0]          mc_to_lsq_data
);

  localparam int DEPTH = 1 << LSQ_WIDTH;
  localparam logic [LSQ_WIDTH:0] DEPTH_CNT = (LSQ_WIDTH + 1)'(DEPTH);

`ifdef LSQ_IO_ORDER_EN
  localparam bit IO_ORDER = 1'b1;
`else
  localparam bit IO_ORDER = 1'b0;
`endif

  typedef struct packed {
    logic [ROB_WIDTH-1:0] rob_index;
    logic [5:0]           op_id;
    logic [ROB_WIDTH-1:0] dep1;
    logic [ROB_WIDTH-1:0] dep2;
    logic [31:0]          val1;
    logic [31:0]          val2;
    logic [31:0]          offset;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [ROB_WIDTH-1:0] wk_dep1 [DEPTH];
  logic [ROB_WIDTH-1:0] wk_dep2 [DEPTH];
  logic [31:0]          wk_val1 [DEPTH];
  logic [31:0]          wk_val2 [DEPTH];

  lsq_state_e           state_q, state_d;
  logic [LSQ_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [LSQ_WIDTH:0]   count_q, count_d;
  logic                 kill_q, kill_d;
  logic [ROB_WIDTH-1:0] cur_rob_q, cur_rob_d;
  logic [5:0]           cur_op_q, cur_op_d;
  logic                 mc_ready_q, mc_ready_d, mc_op_q, mc_op_d;
  logic [2:0]           mc_len_q, mc_len_d;
  logic [31:0]          mc_addr_q, mc_addr_d, mc_data_q, mc_data_d;
  logic                 lsq_ready_q, lsq_ready_d;
  logic [ROB_WIDTH-1:0] lsq_rob_q, lsq_rob_d;
  logic [31:0]          lsq_val_q, lsq_val_d;

  logic                 full, enq, deq, can_dispatch;
  entry_t               head_e, enq_e;
  logic [31:0]          head_addr;
  logic                 head_store, head_at_rob, head_ops_rdy, head_is_io, load_ok;

  // Wake-up compare for every stored entry and for the op being enqueued.
  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    lsq_wakeup_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_cmp1 (
      .dep_i(mem_q[g].dep1), .val_i(mem_q[g].val1),
      .rs_ready_i(rs_ready), .rs_index_i(rs_rob_index), .rs_val_i(rs_val),
      .lsq_ready_i(lsq_ready_q), .lsq_index_i(lsq_rob_q), .lsq_val_i(lsq_val_q),
      .dep_o(wk_dep1[g]), .val_o(wk_val1[g])
    );
    lsq_wakeup_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_cmp2 (
      .dep_i(mem_q[g].dep2), .val_i(mem_q[g].val2),
      .rs_ready_i(rs_ready), .rs_index_i(rs_rob_index), .rs_val_i(rs_val),
      .lsq_ready_i(lsq_ready_q), .lsq_index_i(lsq_rob_q), .lsq_val_i(lsq_val_q),
      .dep_o(wk_dep2[g]), .val_o(wk_val2[g])
    );
  end

  lsq_wakeup_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_enq_cmp1 (
    .dep_i(issue_depend1), .val_i(issue_val1),
    .rs_ready_i(rs_ready), .rs_index_i(rs_rob_index), .rs_val_i(rs_val),
    .lsq_ready_i(lsq_ready_q), .lsq_index_i(lsq_rob_q), .lsq_val_i(lsq_val_q),
    .dep_o(enq_e.dep1), .val_o(enq_e.val1)
  );
  lsq_wakeup_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_enq_cmp2 (
    .dep_i(issue_depend2), .val_i(issue_val2),
    .rs_ready_i(rs_ready), .rs_index_i(rs_rob_index), .rs_val_i(rs_val),
    .lsq_ready_i(lsq_ready_q), .lsq_index_i(lsq_rob_q), .lsq_val_i(lsq_val_q),
    .dep_o(enq_e.dep2), .val_o(enq_e.val2)
  );

  assign enq_e.rob_index = issue_rob_index;
  assign enq_e.op_id     = issue_op_id;
  assign enq_e.offset    = issue_offset;

  // Head-of-queue dispatch qualification.
  assign full         = (count_q == DEPTH_CNT);
  assign enq          = issue_lsq_ready && !clr_in && !full;
  assign head_e       = mem_q[head_q];
  assign head_addr    = head_e.val1 + head_e.offset;
  assign head_store   = is_store(head_e.op_id);
  assign head_at_rob  = (head_e.rob_index == rob_head_index);
  assign head_ops_rdy = (head_e.dep1 == '0) && (head_e.dep2 == '0);
  assign head_is_io   = (head_addr >= IO_BASE);
  assign load_ok      = !IO_ORDER || !head_is_io || head_at_rob;
  assign can_dispatch = (state_q == ST_IDLE) && (count_q != '0) && !clr_in &&
                        head_ops_rdy && (head_store ? head_at_rob : load_ok);

  // Next contents of the entry array: wake-up results plus the new op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]      = mem_q[i];
      mem_d[i].dep1 = wk_dep1[i];
      mem_d[i].dep2 = wk_dep2[i];
      mem_d[i].val1 = wk_val1[i];
      mem_d[i].val2 = wk_val2[i];
      if (enq && tail_q == LSQ_WIDTH'(i)) mem_d[i] = enq_e;
    end
  end

  // FSM next state, memory request and result broadcast.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    cur_rob_d   = cur_rob_q;
    cur_op_d    = cur_op_q;
    mc_ready_d  = mc_ready_q;
    mc_op_d     = mc_op_q;
    mc_len_d    = mc_len_q;
    mc_addr_d   = mc_addr_q;
    mc_data_d   = mc_data_q;
    lsq_ready_d = 1'b0;
    lsq_rob_d   = lsq_rob_q;
    lsq_val_d   = lsq_val_q;
    deq         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_dispatch) begin
          deq        = 1'b1;
          state_d    = ST_WAIT;
          mc_ready_d = 1'b1;
          mc_op_d    = head_store;
          mc_len_d   = op_len(head_e.op_id);
          mc_addr_d  = head_addr;
          mc_data_d  = head_e.val2;
          cur_rob_d  = head_e.rob_index;
          cur_op_d   = head_e.op_id;
        end
      end
      ST_WAIT: begin
        if (mc_to_lsq_ready) begin
          state_d     = ST_IDLE;
          mc_ready_d  = 1'b0;
          kill_d      = 1'b0;
          lsq_ready_d = !kill_q && !clr_in;
          lsq_rob_d   = cur_rob_q;
          lsq_val_d   = load_extend(cur_op_q, mc_to_lsq_data);
        end else if (clr_in) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue pointers and occupancy.
  always_comb begin
    tail_d  = tail_q + LSQ_WIDTH'(enq);
    head_d  = head_q + LSQ_WIDTH'(deq);
    count_d = count_q;
    if (clr_in) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_in) begin
    // NOTE: the entry array has no reset; an entry is only meaningful between
    // head and tail, and both pointers are reset.
    if (rdy_in) mem_q <= mem_d;
  end

  // Control and output registers.
  always_ff @(posedge clk_in) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the values from before this edge.
    if (rst_in) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      kill_q      <= 1'b0;
      cur_rob_q   <= '0;
      cur_op_q    <= '0;
      mc_ready_q  <= 1'b0;
      mc_op_q     <= 1'b0;
      mc_len_q    <= '0;
      mc_addr_q   <= '0;
      mc_data_q   <= '0;
      lsq_ready_q <= 1'b0;
      lsq_rob_q   <= '0;
      lsq_val_q   <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      kill_q      <= kill_d;
      cur_rob_q   <= cur_rob_d;
      cur_op_q    <= cur_op_d;
      mc_ready_q  <= mc_ready_d;
      mc_op_q     <= mc_op_d;
      mc_len_q    <= mc_len_d;
      mc_addr_q   <= mc_addr_d;
      mc_data_q   <= mc_data_d;
      lsq_ready_q <= lsq_ready_d;
      lsq_rob_q   <= lsq_rob_d;
      lsq_val_q   <= lsq_val_d;
    end
  end

  assign lsq_full        = full;
  assign lsq_ready       = lsq_ready_q;
  assign lsq_rob_index   = lsq_rob_q;
  assign lsq_val         = lsq_val_q;
  assign lsq_to_mc_ready = mc_ready_q;
  assign lsq_to_mc_op    = mc_op_q;
  assign lsq_to_mc_len   = mc_len_q;
  assign lsq_to_mc_addr  = mc_addr_q;
  assign lsq_to_mc_data  = mc_data_q;

endmodule
